// File: rtl/vga_timing_gen_pkg.sv
// rtl/vga_timing_gen_pkg.sv - shared 640x480@60 timing defaults and total-count helper
package vga_timing_gen_pkg;

    // 640x480@60 defaults, also used by the pixel/RGB stage for coordinate compares
    localparam int unsigned DEF_CLK_DIV   = 2;
    localparam int unsigned DEF_H_DISPLAY = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_DISPLAY = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;
    localparam int unsigned DEF_CW        = 10;

    // Total counts per line / frame from the four timing segments
    function automatic int unsigned timing_total(
        input int unsigned display,
        input int unsigned front,
        input int unsigned sync,
        input int unsigned back
    );
        return display + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// rtl/vga_pixel_tick.sv - clk divider producing a registered one-clk pixel tick
module vga_pixel_tick #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;
    logic          p_tick_q;
    logic          p_tick_d;

    // Next divider value; the tick is high while the divider sits at its last count
    always_comb begin
        div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        p_tick_d = (div_d == DIV_LAST);
    end

    // Divider and tick registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q    <= '0;
            p_tick_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            p_tick_q <= p_tick_d;
        end
    end

    assign p_tick = p_tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with registered sync/blank decode
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
    parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK,
    parameter bit          SYNC_POL  = 1'b0,
    parameter int unsigned CW        = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic          p_tick,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          frame_tick
);

    localparam int unsigned H_TOTAL = timing_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = timing_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_DISPLAY);
    localparam logic [CW-1:0] V_VIS    = CW'(V_DISPLAY);
    localparam logic [CW-1:0] HS_START = CW'(H_DISPLAY + H_FRONT);
    localparam logic [CW-1:0] HS_END   = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0] VS_START = CW'(V_DISPLAY + V_FRONT);
    localparam logic [CW-1:0] VS_END   = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic          tick_raw;

    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          video_on_q, video_on_d;
    logic          p_tick_q, p_tick_d;
    logic          frame_tick_q, frame_tick_d;

    // The divider's tick is used as the counter enable; the outward p_tick is
    // re-registered here so it lines up with the counter update it caused.
    vga_pixel_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick (
        .clk    (clk),
        .reset  (reset),
        .p_tick (tick_raw)
    );

    // Advance the raster position and decode sync/blank from the new position
    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        hsync_d      = hsync_q;
        vsync_d      = vsync_q;
        video_on_d   = video_on_q;
        p_tick_d     = tick_raw;
        frame_tick_d = 1'b0;
        if (tick_raw) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
            hsync_d      = ((x_d >= HS_START) && (x_d <= HS_END)) ? SYNC_POL : ~SYNC_POL;
            vsync_d      = ((y_d >= VS_START) && (y_d <= VS_END)) ? SYNC_POL : ~SYNC_POL;
            video_on_d   = (x_d < H_VIS) && (y_d < V_VIS);
            frame_tick_d = (x_d == '0) && (y_d == '0);
        end
    end

    // Raster state; reset parks at the last position so the first tick enters (0,0)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q          <= H_LAST;
            y_q          <= V_LAST;
            hsync_q      <= ~SYNC_POL;
            vsync_q      <= ~SYNC_POL;
            video_on_q   <= 1'b0;
            p_tick_q     <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            video_on_q   <= video_on_d;
            p_tick_q     <= p_tick_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign pixel_x    = x_q;
    assign pixel_y    = y_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign video_on   = video_on_q;
    assign p_tick     = p_tick_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen on a reduced raster
module tb_vga_timing_gen;

    localparam int D   = 2;
    localparam int HD  = 8;
    localparam int HF  = 2;
    localparam int HSW = 3;
    localparam int HB  = 2;
    localparam int VD  = 6;
    localparam int VF  = 1;
    localparam int VSW = 2;
    localparam int VB  = 1;
    localparam int CW  = 5;
    localparam bit POL = 1'b0;
    localparam int HT  = HD + HF + HSW + HB;
    localparam int VT  = VD + VF + VSW + VB;
    // First tick: one clk to load the divider's registered tick, then the divide period
    localparam int FIRST_TICK = (D > 1) ? D : 2;

    typedef struct {
        int edge_n;
        int x;
        int y;
        bit hs;
        bit vs;
        bit von;
        bit ft;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic          p_tick;
    logic [CW-1:0] pixel_x;
    logic [CW-1:0] pixel_y;
    logic          frame_tick;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   rel_edge = 0;
    exp_t exp_q[$];
    exp_t hold;

    vga_timing_gen #(
        .CLK_DIV   (D),
        .H_DISPLAY (HD),
        .H_FRONT   (HF),
        .H_SYNC    (HSW),
        .H_BACK    (HB),
        .V_DISPLAY (VD),
        .V_FRONT   (VF),
        .V_SYNC    (VSW),
        .V_BACK    (VB),
        .SYNC_POL  (POL),
        .CW        (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hsync      (hsync),
        .vsync      (vsync),
        .video_on   (video_on),
        .p_tick     (p_tick),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) rel_edge = rel_edge + 1;
        else       rel_edge = 0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] pk(input int x, input int y, input bit hs, input bit vs,
                                       input bit von, input bit ft, input bit pt);
        logic [15:0] xv;
        logic [10:0] yv;
        xv = 16'(x);
        yv = 11'(y);
        return {pt, ft, von, vs, hs, yv, xv};
    endfunction

    function automatic logic [31:0] dut_pk();
        return {p_tick, frame_tick, video_on, vsync, hsync, 11'(pixel_y), 16'(pixel_x)};
    endfunction

    // Reference: the n-th pixel tick after release shows raster position n (mod frame)
    function automatic exp_t model(input int n);
        exp_t e;
        int   p;
        p       = n % (HT * VT);
        e.edge_n = FIRST_TICK + n * D;
        e.x     = p % HT;
        e.y     = p / HT;
        e.hs    = (e.x >= HD + HF && e.x < HD + HF + HSW) ? POL : !POL;
        e.vs    = (e.y >= VD + VF && e.y < VD + VF + VSW) ? POL : !POL;
        e.von   = (e.x < HD) && (e.y < VD);
        e.ft    = (p == 0);
        return e;
    endfunction

    function automatic exp_t reset_state();
        exp_t e;
        e.edge_n = 0;
        e.x      = HT - 1;
        e.y      = VT - 1;
        e.hs     = !POL;
        e.vs     = !POL;
        e.von    = 1'b0;
        e.ft     = 1'b0;
        return e;
    endfunction

    // Monitor: pop an expectation on every tick, otherwise outputs must hold
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            hold = reset_state();
            check("reset_state", dut_pk(), pk(hold.x, hold.y, hold.hs, hold.vs, hold.von, 1'b0, 1'b0));
        end else if (p_tick) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_tick: got tick at edge %0d expected none", rel_edge);
            end else begin
                e = exp_q.pop_front();
                check("tick_edge", rel_edge, e.edge_n);
                check("tick_outputs", dut_pk(), pk(e.x, e.y, e.hs, e.vs, e.von, e.ft, 1'b1));
                hold    = e;
                hold.ft = 1'b0;
            end
        end else begin
            check("between_ticks", dut_pk(), pk(hold.x, hold.y, hold.hs, hold.vs, hold.von, 1'b0, 1'b0));
        end
    end

    // Release reset for len clks, expecting every tick that lands in that window
    task automatic run_segment(input int len, input bit in_hsync);
        @(negedge clk);
        #1;
        reset = 1'b1;
        for (int n = 0; FIRST_TICK + n * D <= len; n++) exp_q.push_back(model(n));
        repeat (len) @(posedge clk);
        @(negedge clk);
        #1;
        if (in_hsync) check("hsync_active_before_reset", hsync, POL);
        #1;
        reset = 1'b0;
        #1;
        check("async_reset_outputs", dut_pk(),
              pk(HT - 1, VT - 1, !POL, !POL, 1'b0, 1'b0, 1'b0));
        check("all_ticks_seen", exp_q.size(), 0);
        exp_q.delete();
        repeat ($urandom_range(1, 5)) @(posedge clk);
    endtask

    initial begin
        hold  = reset_state();
        reset = 1'b0;
        repeat (5) @(posedge clk);
        // stop with the last tick in the middle of hsync on the third line
        run_segment(FIRST_TICK + (2 * HT + HD + HF + 1) * D, 1'b1);
        // three complete frames plus a few pixels of the fourth
        run_segment(HT * VT * D * 3 + 5, 1'b0);
        for (int i = 0; i < 8; i++) run_segment($urandom_range(1, HT * VT * D + 40), 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
